// File: rtl/udma_eth_rx_slot_manager_if.sv
// ---------------------------------------------------------------------------
// udma_eth_rx_slot_manager_if
//
// Bundles every non-clock/reset signal of the RX slot manager.
//   alloc_*              : slot request/grant handshake with the RX stream
//                          controller, plus the granted slot's start address
//   fill_done/fill_size  : packet completion report from the RX controller
//   reg_startaddr0..3    : per-slot L2 start addresses from the register file
//   reg_release/reg_clr  : software pop of the head slot / synchronous flush
//   reg_head_* / counts  : ready-queue head and status back to the registers
//   eth_*_event          : single-cycle event pulses
//
// Modports:
//   master : environment side (RX controller + register file)
//   slave  : the slot manager itself
// ---------------------------------------------------------------------------
interface udma_eth_rx_slot_manager_if #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int DROP_CNT_W     = 16
);
    logic                      alloc_req_i;
    logic                      alloc_gnt_o;
    logic                      alloc_nack_o;
    logic [1:0]                alloc_slot_o;
    logic [L2_AWIDTH_NOAL-1:0] alloc_addr_o;
    logic [L2_AWIDTH_NOAL-1:0] reg_startaddr0_i;
    logic [L2_AWIDTH_NOAL-1:0] reg_startaddr1_i;
    logic [L2_AWIDTH_NOAL-1:0] reg_startaddr2_i;
    logic [L2_AWIDTH_NOAL-1:0] reg_startaddr3_i;
    logic                      fill_done_i;
    logic [TRANS_SIZE-1:0]     fill_size_i;
    logic                      reg_release_i;
    logic                      reg_clr_i;
    logic                      reg_head_valid_o;
    logic [1:0]                reg_head_slot_o;
    logic [TRANS_SIZE-1:0]     reg_head_size_o;
    logic [2:0]                reg_free_cnt_o;
    logic [DROP_CNT_W-1:0]     reg_drop_cnt_o;
    logic                      eth_rx_event_o;
    logic                      eth_error_event_o;

    modport master (
        output alloc_req_i, fill_done_i, fill_size_i,
        output reg_startaddr0_i, reg_startaddr1_i, reg_startaddr2_i, reg_startaddr3_i,
        output reg_release_i, reg_clr_i,
        input  alloc_gnt_o, alloc_nack_o, alloc_slot_o, alloc_addr_o,
        input  reg_head_valid_o, reg_head_slot_o, reg_head_size_o,
        input  reg_free_cnt_o, reg_drop_cnt_o, eth_rx_event_o, eth_error_event_o
    );

    modport slave (
        input  alloc_req_i, fill_done_i, fill_size_i,
        input  reg_startaddr0_i, reg_startaddr1_i, reg_startaddr2_i, reg_startaddr3_i,
        input  reg_release_i, reg_clr_i,
        output alloc_gnt_o, alloc_nack_o, alloc_slot_o, alloc_addr_o,
        output reg_head_valid_o, reg_head_slot_o, reg_head_size_o,
        output reg_free_cnt_o, reg_drop_cnt_o, eth_rx_event_o, eth_error_event_o
    );
endinterface

// File: rtl/udma_eth_rx_slot_manager.sv
// ---------------------------------------------------------------------------
// udma_eth_rx_slot_manager
//
// Owns four L2 receive slots. Grants one FREE slot per packet request from
// the RX stream controller, queues completed slots in grant order for
// software, and returns the head slot to the free pool on software release.
//
// Ports:
//   sys_clk_i  : system clock
//   sys_rstn_i : asynchronous active-low reset
//   bus        : udma_eth_rx_slot_manager_if.slave (handshake, register and
//                event signals; see the interface file)
// ---------------------------------------------------------------------------
module udma_eth_rx_slot_manager #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int DROP_CNT_W     = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rstn_i,
    udma_eth_rx_slot_manager_if.slave     bus
);

    localparam logic [1:0] SLOT_FREE    = 2'd0;
    localparam logic [1:0] SLOT_FILLING = 2'd1;
    localparam logic [1:0] SLOT_FULL    = 2'd2;

    // NACK is the response cycle of a refusal: it keeps a still-high request
    // from being evaluated twice. BUSY covers the grant cycle and the fill.
    typedef enum logic [1:0] {IDLE, NACK, BUSY} fsm_e;

    fsm_e                  state_reg, state_next;
    logic [1:0]            slot_state_reg  [4];
    logic [1:0]            slot_state_next [4];
    logic [1:0]            alloc_ptr_reg, alloc_ptr_next;
    logic [1:0]            alloc_slot_reg, alloc_slot_next;
    logic                  gnt_reg, gnt_next;
    logic                  nack_reg, nack_next;
    logic                  rx_evt_reg, rx_evt_next;
    logic                  err_evt_reg, err_evt_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [2:0]            free_cnt_reg, free_cnt_next;

    // Ready queue: slot indices in grant order, plus one size per slot.
    logic [1:0]            q_mem_reg [4];
    logic [1:0]            q_rd_ptr_reg, q_rd_ptr_next;
    logic [1:0]            q_wr_ptr_reg, q_wr_ptr_next;
    logic [2:0]            q_cnt_reg, q_cnt_next;
    logic [TRANS_SIZE-1:0] size_reg [4];

    logic                  push, pop;
    logic [1:0]            head_slot;
    logic [3:0]            slot_is_free;
    logic                  free_found;
    logic [1:0]            free_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_free
            assign slot_is_free[gi] = (slot_state_reg[gi] == SLOT_FREE);
        end
    endgenerate

    assign head_slot = q_mem_reg[q_rd_ptr_reg];

    // First FREE slot at or after alloc_ptr, wrapping mod 4. Scanning the
    // offsets downward lets the smallest offset win.
    always_comb begin
        logic [1:0] cand;
        free_found = 1'b0;
        free_idx   = alloc_ptr_reg;
        cand       = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = alloc_ptr_reg + 2'(i);
            if (slot_is_free[cand]) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        slot_state_next = slot_state_reg;
        alloc_ptr_next  = alloc_ptr_reg;
        alloc_slot_next = alloc_slot_reg;
        gnt_next        = 1'b0;
        nack_next       = 1'b0;
        rx_evt_next     = 1'b0;
        err_evt_next    = 1'b0;
        drop_cnt_next   = drop_cnt_reg;
        push            = 1'b0;
        pop             = 1'b0;

        // Release on an empty queue is a software error, not a state change.
        if (bus.reg_release_i) begin
            if (q_cnt_reg != 3'd0) pop = 1'b1;
            else                   err_evt_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // Evaluated against the pre-release pool: a slot freed by a
                // release in this same cycle cannot be granted yet.
                if (bus.alloc_req_i) begin
                    if (free_found) begin
                        gnt_next                  = 1'b1;
                        alloc_slot_next           = free_idx;
                        slot_state_next[free_idx] = SLOT_FILLING;
                        alloc_ptr_next            = free_idx + 2'd1;
                        state_next                = BUSY;
                    end else begin
                        nack_next    = 1'b1;
                        err_evt_next = 1'b1;
                        if (drop_cnt_reg != '1)
                            drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
                        state_next   = NACK;
                    end
                end
            end
            NACK: begin
                state_next = IDLE;
            end
            BUSY: begin
                if (bus.fill_done_i) begin
                    if (bus.fill_size_i != '0) begin
                        slot_state_next[alloc_slot_reg] = SLOT_FULL;
                        push        = 1'b1;
                        rx_evt_next = 1'b1;
                    end else begin
                        slot_state_next[alloc_slot_reg] = SLOT_FREE;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The popped slot is FULL, so it never collides with the FILLING one.
        if (pop) slot_state_next[head_slot] = SLOT_FREE;

        q_wr_ptr_next = q_wr_ptr_reg + {1'b0, push};
        q_rd_ptr_next = q_rd_ptr_reg + {1'b0, pop};
        q_cnt_next    = q_cnt_reg + {2'b00, push} - {2'b00, pop};

        if (bus.reg_clr_i) begin
            state_next      = IDLE;
            slot_state_next = '{default: SLOT_FREE};
            alloc_ptr_next  = '0;
            alloc_slot_next = '0;
            gnt_next        = 1'b0;
            nack_next       = 1'b0;
            rx_evt_next     = 1'b0;
            err_evt_next    = 1'b0;
            drop_cnt_next   = '0;
            push            = 1'b0;
            q_wr_ptr_next   = '0;
            q_rd_ptr_next   = '0;
            q_cnt_next      = '0;
        end

        free_cnt_next = '0;
        for (int i = 0; i < 4; i++) begin
            if (slot_state_next[i] == SLOT_FREE) free_cnt_next = free_cnt_next + 3'd1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_reg      <= IDLE;
            slot_state_reg <= '{default: SLOT_FREE};
            alloc_ptr_reg  <= '0;
            alloc_slot_reg <= '0;
            gnt_reg        <= 1'b0;
            nack_reg       <= 1'b0;
            rx_evt_reg     <= 1'b0;
            err_evt_reg    <= 1'b0;
            drop_cnt_reg   <= '0;
            free_cnt_reg   <= 3'd4;
            q_rd_ptr_reg   <= '0;
            q_wr_ptr_reg   <= '0;
            q_cnt_reg      <= '0;
            q_mem_reg      <= '{default: 2'd0};
            size_reg       <= '{default: '0};
        end else begin
            state_reg      <= state_next;
            slot_state_reg <= slot_state_next;
            alloc_ptr_reg  <= alloc_ptr_next;
            alloc_slot_reg <= alloc_slot_next;
            gnt_reg        <= gnt_next;
            nack_reg       <= nack_next;
            rx_evt_reg     <= rx_evt_next;
            err_evt_reg    <= err_evt_next;
            drop_cnt_reg   <= drop_cnt_next;
            free_cnt_reg   <= free_cnt_next;
            q_rd_ptr_reg   <= q_rd_ptr_next;
            q_wr_ptr_reg   <= q_wr_ptr_next;
            q_cnt_reg      <= q_cnt_next;
            if (push) begin
                q_mem_reg[q_wr_ptr_reg] <= alloc_slot_reg;
                size_reg[alloc_slot_reg] <= bus.fill_size_i;
            end
        end
    end

    always_comb begin
        case (alloc_slot_reg)
            2'd0:    bus.alloc_addr_o = bus.reg_startaddr0_i;
            2'd1:    bus.alloc_addr_o = bus.reg_startaddr1_i;
            2'd2:    bus.alloc_addr_o = bus.reg_startaddr2_i;
            default: bus.alloc_addr_o = bus.reg_startaddr3_i;
        endcase
    end

    // Head fields read as zero while the queue is empty.
    assign bus.reg_head_valid_o  = (q_cnt_reg != 3'd0);
    assign bus.reg_head_slot_o   = bus.reg_head_valid_o ? head_slot : 2'd0;
    assign bus.reg_head_size_o   = bus.reg_head_valid_o ? size_reg[head_slot] : '0;
    assign bus.alloc_gnt_o       = gnt_reg;
    assign bus.alloc_nack_o      = nack_reg;
    assign bus.alloc_slot_o      = alloc_slot_reg;
    assign bus.reg_free_cnt_o    = free_cnt_reg;
    assign bus.reg_drop_cnt_o    = drop_cnt_reg;
    assign bus.eth_rx_event_o    = rx_evt_reg;
    assign bus.eth_error_event_o = err_evt_reg;

endmodule
